// File: rtl/time_set_ctrl.sv
// -----------------------------------------------------------------------------
// time_set_ctrl
//
// Timekeeping controller for the digital clock. It holds the hour, minute and
// second registers and advances them on the 1 s pulse. A button-driven set
// mode edits one field at a time while counting is frozen. It also drives the
// display path: time fields, current mode and a per-field blank mask.
//
// Parameters:
//   HOUR_MAX   last hour value before the wrap to 0 (1..31, 23 = 24 h clock)
//
// Ports:
//   clk        system clock, rising edge
//   rst_p      synchronous, active-high reset
//   tick_1s    single-cycle pulse, once per second
//   btn_mode   debounced pulse, RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN
//   btn_inc    debounced pulse, +1 on the field under edit
//   btn_dec    debounced pulse, -1 on the field under edit
//   sec        seconds 0..59
//   min        minutes 0..59
//   hour       hours 0..HOUR_MAX
//   mode       00 RUN, 01 SET_HOUR, 10 SET_MIN, 11 SET_SEC
//   blank      display blank mask: [2] hour, [1] min, [0] sec
//   min_tick   one-cycle pulse when seconds wrap 59->0 in RUN
//   hour_tick  one-cycle pulse when minutes wrap 59->0 in RUN
//
// Configuration macro:
//   BLINK_EN   when defined, the field under edit blinks (1 s on / 1 s off)
//              through blank; when undefined, blank is tied to 000 and the
//              blink phase register does not exist.
// -----------------------------------------------------------------------------
module time_set_ctrl #(
    parameter int HOUR_MAX = 23
) (
    input  logic       clk,
    input  logic       rst_p,
    input  logic       tick_1s,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hour,
    output logic [1:0] mode,
    output logic [2:0] blank,
    output logic       min_tick,
    output logic       hour_tick
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10,
        SET_SEC  = 2'b11
    } state_t;

    localparam logic [5:0] MS_MAX = 6'd59;
    localparam logic [4:0] HR_MAX = 5'(HOUR_MAX);

    state_t state;
    state_t state_next;
    logic   edit_up;
    logic   edit_dn;

    // Wrap-around step helpers for the 6-bit (min/sec) and 5-bit (hour) fields.
    function automatic logic [5:0] ms_inc(input logic [5:0] v);
        return (v == MS_MAX) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [5:0] ms_dec(input logic [5:0] v);
        return (v == 6'd0) ? MS_MAX : v - 6'd1;
    endfunction

    function automatic logic [4:0] hr_inc(input logic [4:0] v);
        return (v == HR_MAX) ? 5'd0 : v + 5'd1;
    endfunction

    function automatic logic [4:0] hr_dec(input logic [4:0] v);
        return (v == 5'd0) ? HR_MAX : v - 5'd1;
    endfunction

    // A mode press discards any edit in the same cycle; inc and dec together
    // cancel each other out.
    assign edit_up = btn_inc & ~btn_dec & ~btn_mode;
    assign edit_dn = btn_dec & ~btn_inc & ~btn_mode;

    // The state encoding is the mode code, and the sequence is a plain
    // modulo-4 count, so the next state is state + 1 on a mode press.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        state_next = state;
        if (btn_mode) begin
            state_next = state_t'(state + 2'd1);
        end
    end

    assign mode = state;

`ifdef BLINK_EN
    logic       phase;
    logic       phase_next;
    logic [2:0] blank_next;

    // Phase restarts at 0 on any state change so a freshly selected field
    // is shown first; it only toggles while editing.
    always_comb begin
        phase_next = phase;
        if (state_next != state) begin
            phase_next = 1'b0;
        end else if (tick_1s && state != RUN) begin
            phase_next = ~phase;
        end
    end

    // blank is registered from the next-state view so it lines up with the
    // mode output on the same cycle.
    always_comb begin
        blank_next = 3'b000;
        if (phase_next) begin
            case (state_next)
                SET_HOUR: blank_next = 3'b100;
                SET_MIN:  blank_next = 3'b010;
                SET_SEC:  blank_next = 3'b001;
                default:  blank_next = 3'b000;
            endcase
        end
    end
`else
    assign blank = 3'b000;
`endif

    always_ff @(posedge clk) begin
        // NOTE: registers are updated with non-blocking assignments so every
        // decision below sees the values from before this edge.
        if (rst_p) begin
            state     <= RUN;
            sec       <= 6'd0;
            min       <= 6'd0;
            hour      <= 5'd0;
            min_tick  <= 1'b0;
            hour_tick <= 1'b0;
`ifdef BLINK_EN
            phase     <= 1'b0;
            blank     <= 3'b000;
`endif
        end else begin
            state     <= state_next;
            min_tick  <= 1'b0;
            hour_tick <= 1'b0;

            // Actions follow the current state, so a tick arriving with a
            // mode press in RUN still counts.
            case (state)
                RUN: begin
                    if (tick_1s) begin
                        if (sec == MS_MAX) begin
                            sec      <= 6'd0;
                            min_tick <= 1'b1;
                            if (min == MS_MAX) begin
                                min       <= 6'd0;
                                hour      <= hr_inc(hour);
                                hour_tick <= 1'b1;
                            end else begin
                                min <= min + 6'd1;
                            end
                        end else begin
                            sec <= sec + 6'd1;
                        end
                    end
                end
                SET_HOUR: begin
                    if (edit_up)      hour <= hr_inc(hour);
                    else if (edit_dn) hour <= hr_dec(hour);
                end
                SET_MIN: begin
                    if (edit_up)      min <= ms_inc(min);
                    else if (edit_dn) min <= ms_dec(min);
                end
                SET_SEC: begin
                    if (edit_up)      sec <= ms_inc(sec);
                    else if (edit_dn) sec <= ms_dec(sec);
                end
                default: ;
            endcase

`ifdef BLINK_EN
            phase <= phase_next;
            blank <= blank_next;
`endif
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_time_set_ctrl
//
// Self-checking bench for time_set_ctrl (HOUR_MAX = 23). A table of
// {inputs, expected outputs} records covers RUN counting, set-mode editing,
// wrap and simultaneous-button cases; hand-written sequences cover the full
// minute roll-over, the 23:59:59 cascade and reset in the middle of editing.
// Expected blank values assume BLINK_EN; they are forced to 000 otherwise.
// -----------------------------------------------------------------------------
module tb_time_set_ctrl;

    typedef struct packed {
        logic [5:0] sec;
        logic [5:0] min;
        logic [4:0] hour;
        logic [1:0] mode;
        logic [2:0] blank;
        logic       mt;
        logic       ht;
    } out_t;

    typedef struct {
        logic tick;
        logic bm;
        logic bi;
        logic bd;
        out_t exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_p;
    logic       tick_1s;
    logic       btn_mode;
    logic       btn_inc;
    logic       btn_dec;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic [1:0] mode;
    logic [2:0] blank;
    logic       min_tick;
    logic       hour_tick;

    int   n_pass  = 0;
    int   n_total = 0;
    out_t exp_q[$];

    always #5 clk = ~clk;

    time_set_ctrl #(.HOUR_MAX(23)) dut (
        .clk       (clk),
        .rst_p     (rst_p),
        .tick_1s   (tick_1s),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .btn_dec   (btn_dec),
        .sec       (sec),
        .min       (min),
        .hour      (hour),
        .mode      (mode),
        .blank     (blank),
        .min_tick  (min_tick),
        .hour_tick (hour_tick)
    );

    function automatic out_t mk(input int s, input int mi, input int h,
                                input int md, input int b, input int mt,
                                input int ht);
        out_t o;
        o.sec  = 6'(s);
        o.min  = 6'(mi);
        o.hour = 5'(h);
        o.mode = 2'(md);
`ifdef BLINK_EN
        o.blank = 3'(b);
`else
        o.blank = 3'b000;
`endif
        o.mt = 1'(mt);
        o.ht = 1'(ht);
        return o;
    endfunction

    function automatic vec_t v(input logic t, input logic bm, input logic bi,
                               input logic bd, input out_t e);
        vec_t r;
        r.tick = t;
        r.bm   = bm;
        r.bi   = bi;
        r.bd   = bd;
        r.exp  = e;
        return r;
    endfunction

    task automatic check(input string name, input out_t act, input out_t exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d:%0d:%0d mode=%0d blank=%b mt=%b ht=%b, expected %0d:%0d:%0d mode=%0d blank=%b mt=%b ht=%b",
                     name, act.hour, act.min, act.sec, act.mode, act.blank, act.mt, act.ht,
                     exp.hour, exp.min, exp.sec, exp.mode, exp.blank, exp.mt, exp.ht);
        end
    endtask

    // Drive one cycle of inputs, queue the expectation, sample #1 after the edge.
    task automatic step(input string name, input logic r, input logic t,
                        input logic bm, input logic bi, input logic bd,
                        input out_t e);
        out_t act;
        rst_p    = r;
        tick_1s  = t;
        btn_mode = bm;
        btn_inc  = bi;
        btn_dec  = bd;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        rst_p    = 1'b0;
        tick_1s  = 1'b0;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        btn_dec  = 1'b0;
        act = {sec, min, hour, mode, blank, min_tick, hour_tick};
        check(name, act, exp_q.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[26];

        // tick, mode, inc, dec | sec, min, hour, mode, blank, min_tick, hour_tick
        vecs[0]  = v(1, 0, 0, 0, mk( 1,  0,  0, 0, 0, 0, 0));
        vecs[1]  = v(0, 0, 1, 0, mk( 1,  0,  0, 0, 0, 0, 0)); // inc ignored in RUN
        vecs[2]  = v(0, 0, 0, 1, mk( 1,  0,  0, 0, 0, 0, 0)); // dec ignored in RUN
        vecs[3]  = v(0, 1, 0, 0, mk( 1,  0,  0, 1, 0, 0, 0));
        vecs[4]  = v(0, 0, 0, 1, mk( 1,  0, 23, 1, 0, 0, 0)); // hour 0 -> 23
        vecs[5]  = v(1, 0, 0, 0, mk( 1,  0, 23, 1, 4, 0, 0)); // frozen, blink on
        vecs[6]  = v(0, 0, 1, 0, mk( 1,  0,  0, 1, 4, 0, 0)); // hour 23 -> 0
        vecs[7]  = v(1, 0, 1, 0, mk( 1,  0,  1, 1, 0, 0, 0));
        vecs[8]  = v(0, 0, 1, 1, mk( 1,  0,  1, 1, 0, 0, 0)); // inc+dec cancel
        vecs[9]  = v(0, 1, 1, 0, mk( 1,  0,  1, 2, 0, 0, 0)); // edit discarded
        vecs[10] = v(0, 0, 0, 1, mk( 1, 59,  1, 2, 0, 0, 0));
        vecs[11] = v(0, 0, 1, 0, mk( 1,  0,  1, 2, 0, 0, 0)); // no carry to hour
        vecs[12] = v(0, 0, 1, 0, mk( 1,  1,  1, 2, 0, 0, 0));
        vecs[13] = v(0, 1, 1, 0, mk( 1,  1,  1, 3, 0, 0, 0)); // min unchanged
        vecs[14] = v(1, 0, 0, 0, mk( 1,  1,  1, 3, 1, 0, 0));
        vecs[15] = v(1, 0, 0, 0, mk( 1,  1,  1, 3, 0, 0, 0));
        vecs[16] = v(0, 0, 1, 1, mk( 1,  1,  1, 3, 0, 0, 0)); // sec unchanged
        vecs[17] = v(0, 0, 0, 1, mk( 0,  1,  1, 3, 0, 0, 0));
        vecs[18] = v(0, 0, 0, 1, mk(59,  1,  1, 3, 0, 0, 0)); // sec 0 -> 59
        vecs[19] = v(1, 1, 0, 0, mk(59,  1,  1, 0, 0, 0, 0)); // tick not counted
        vecs[20] = v(1, 0, 0, 0, mk( 0,  2,  1, 0, 0, 1, 0)); // resumes from 59
        vecs[21] = v(0, 0, 0, 0, mk( 0,  2,  1, 0, 0, 0, 0));
        vecs[22] = v(1, 1, 0, 0, mk( 1,  2,  1, 1, 0, 0, 0)); // count + advance
        vecs[23] = v(0, 1, 0, 0, mk( 1,  2,  1, 2, 0, 0, 0));
        vecs[24] = v(0, 1, 0, 0, mk( 1,  2,  1, 3, 0, 0, 0));
        vecs[25] = v(0, 1, 0, 0, mk( 1,  2,  1, 0, 0, 0, 0));

        rst_p = 1'b1; tick_1s = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;

        // Reset state, with other inputs active to show reset priority.
        step("reset_init", 1, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));
        step("reset_prio", 1, 1, 1, 1, 0, mk(0, 0, 0, 0, 0, 0, 0));

        for (int k = 0; k < 26; k++) begin
            step($sformatf("vec%0d", k), 1'b0, vecs[k].tick, vecs[k].bm,
                 vecs[k].bi, vecs[k].bd, vecs[k].exp);
        end

        // Full minute of ticks in RUN from reset.
        step("reset_a", 1, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 60; i++) begin
            step($sformatf("run_tick%0d", i), 0, 1, 0, 0, 0,
                 mk((i + 1) % 60, (i == 59) ? 1 : 0, 0, 0, 0, (i == 59) ? 1 : 0, 0));
        end
        step("min_tick_low", 0, 0, 0, 0, 0, mk(0, 1, 0, 0, 0, 0, 0));

        // Preload 23:59:59 and cascade on one tick.
        step("c_sethour", 0, 0, 1, 0, 0, mk( 0,  1,  0, 1, 0, 0, 0));
        step("c_hour23",  0, 0, 0, 0, 1, mk( 0,  1, 23, 1, 0, 0, 0));
        step("c_setmin",  0, 0, 1, 0, 0, mk( 0,  1, 23, 2, 0, 0, 0));
        step("c_min0",    0, 0, 0, 0, 1, mk( 0,  0, 23, 2, 0, 0, 0));
        step("c_min59",   0, 0, 0, 0, 1, mk( 0, 59, 23, 2, 0, 0, 0));
        step("c_setsec",  0, 0, 1, 0, 0, mk( 0, 59, 23, 3, 0, 0, 0));
        step("c_sec59",   0, 0, 0, 0, 1, mk(59, 59, 23, 3, 0, 0, 0));
        step("c_run",     0, 0, 1, 0, 0, mk(59, 59, 23, 0, 0, 0, 0));
        step("cascade",   0, 1, 0, 0, 0, mk( 0,  0,  0, 0, 0, 1, 1));
        step("c_idle",    0, 0, 0, 0, 0, mk( 0,  0,  0, 0, 0, 0, 0));

        // Build 12:34:56, sit in SET_MIN with blink on, then reset.
        for (int i = 0; i < 56; i++) begin
            step($sformatf("r_sec%0d", i + 1), 0, 1, 0, 0, 0, mk(i + 1, 0, 0, 0, 0, 0, 0));
        end
        step("r_sethour", 0, 0, 1, 0, 0, mk(56, 0, 0, 1, 0, 0, 0));
        for (int i = 0; i < 12; i++) begin
            step($sformatf("r_hour%0d", i + 1), 0, 0, 0, 1, 0, mk(56, 0, i + 1, 1, 0, 0, 0));
        end
        step("r_setmin", 0, 0, 1, 0, 0, mk(56, 0, 12, 2, 0, 0, 0));
        for (int i = 0; i < 34; i++) begin
            step($sformatf("r_min%0d", i + 1), 0, 0, 0, 1, 0, mk(56, i + 1, 12, 2, 0, 0, 0));
        end
        step("r_blink",   0, 1, 0, 0, 0, mk(56, 34, 12, 2, 2, 0, 0));
        step("r_reset",   1, 1, 0, 1, 0, mk( 0,  0,  0, 0, 0, 0, 0));
        step("r_after",   0, 1, 0, 0, 0, mk( 1,  0,  0, 0, 0, 0, 0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
